// File: rtl/ram_pkg.sv
// Shared widths and FSM state encoding for the 16-word x 16-bit burst-writer RAM.
package ram_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/memory_RAM_16bit_4bit.sv
// Simple dual-port storage: one synchronous write port and one registered,
// read-first read port with its own enable.
module memory_RAM_16bit_4bit #(
  parameter int unsigned DATA_W = ram_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] out_q;

  // Array is intentionally not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Non-blocking read of the array gives old data on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (en) begin
      out_q <= mem_q[address];
    end
  end

  assign out = out_q;

endmodule

// File: rtl/ram_burst_writer_16bit_4bit.sv
// Burst writer: accepts a start/base/length request, then streams wr_valid
// words into consecutive (wrapping) RAM addresses; read port is free-running.
module ram_burst_writer_16bit_4bit #(
  parameter int unsigned DATA_W = ram_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   burst_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  input  logic              en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  import ram_pkg::*;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept_c;
  logic              len_ok_c;

  assign accept_c = wr_valid & wr_ready_q;
  assign len_ok_c = (burst_len != '0) && (burst_len <= MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Outputs are registered by decoding them from the next state.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;

    unique case (state_q)
      IDLE: begin
        if (start && len_ok_c) begin
          state_d     = WRITE;
          wr_ptr_d    = base_addr;
          remaining_d = burst_len;
        end
      end
      WRITE: begin
        if (accept_c) begin
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - ONE_LEN;
          if (remaining_q == ONE_LEN) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_ready_d = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  memory_RAM_16bit_4bit #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (accept_c),
    .waddr  (wr_ptr_q),
    .wdata  (wr_data),
    .en     (en),
    .address(address),
    .out    (out)
  );

endmodule

// File: tb/tb_ram_burst_writer_16bit_4bit.sv
// Self-checking bench: directed burst table, hand-written corner sequences and
// randomized bursts against a plain array model of the RAM.
module tb_ram_burst_writer_16bit_4bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  burst_len;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        en;
  logic [3:0]  address;
  logic [15:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model [16];

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  len;
    logic [15:0] first;
    logic [15:0] stp;
    bit          exp_ok;
  } vec_t;

  vec_t vecs [7];

  ram_burst_writer_16bit_4bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .burst_len(burst_len),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .en       (en),
    .address  (address),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic readback(input logic [3:0] base, input int len);
    for (int k = 0; k < len; k++) begin
      en      = 1'b1;
      address = 4'(base + 4'(k));
      @(negedge clk);
      check("readback", 32'(out), 32'(model[4'(base + 4'(k))]));
    end
    en = 1'b0;
  endtask

  // mode 0: continuous valid; 1: random valid plus random reads; 2: 3-cycle stall with start pulse
  task automatic do_burst(input logic [3:0] base, input logic [4:0] len, input logic [15:0] first,
                          input logic [15:0] stp, input bit ok, input int mode);
    int          k = 0;
    int          cyc = 0;
    int          stall = 0;
    bit          v;
    bit          re;
    logic [3:0]  ra;
    logic [15:0] exp_rd;
    logic [15:0] d;
    start = 1'b1; base_addr = base; burst_len = len; en = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(ok));
    check("ready_after_start", 32'(wr_ready), 32'(ok));
    if (!ok) begin
      @(negedge clk);
      check("invalid_len_no_done", 32'(done), 32'd0);
      check("invalid_len_idle", 32'(busy), 32'd0);
      return;
    end
    while (k < int'(len)) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = ($urandom_range(0, 3) != 0);
      else begin
        v = !(k == 1 && stall < 3);
        if (!v) begin
          stall++;
          start = 1'b1; base_addr = 4'(base + 4'd7); burst_len = 5'd2;
        end
      end
      re = (mode == 1) && ($urandom_range(0, 1) == 1);
      ra = 4'($urandom_range(0, 15));
      d  = 16'(first + 16'(k) * stp);
      wr_valid = v; wr_data = d; en = re; address = ra;
      if (re) exp_rd = model[ra];
      if (v) begin
        model[4'(base + 4'(k))] = d;
        k++;
      end
      @(negedge clk);
      start = 1'b0;
      if (re) check("read_during_burst", 32'(out), 32'(exp_rd));
      if (k < int'(len)) begin
        check("ready_in_write", 32'(wr_ready), 32'd1);
        check("no_early_done", 32'(done), 32'd0);
      end else begin
        check("done_after_last", 32'(done), 32'd1);
        check("ready_low_in_done", 32'(wr_ready), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
      end
      cyc++;
      if (cyc > 400) begin
        check("burst_cycle_budget", 32'(cyc), 32'd400);
        break;
      end
    end
    wr_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    logic [4:0]  rlen;
    logic [3:0]  rbase;
    int          r;

    vecs[0] = '{base: 4'd0,  len: 5'd16, first: 16'h0100, stp: 16'h0001, exp_ok: 1'b1};
    vecs[1] = '{base: 4'd3,  len: 5'd4,  first: 16'hA001, stp: 16'h0001, exp_ok: 1'b1};
    vecs[2] = '{base: 4'd14, len: 5'd4,  first: 16'h1111, stp: 16'h1111, exp_ok: 1'b1};
    vecs[3] = '{base: 4'd5,  len: 5'd0,  first: 16'hDEAD, stp: 16'h0001, exp_ok: 1'b0};
    vecs[4] = '{base: 4'd9,  len: 5'd17, first: 16'hDEAD, stp: 16'h0001, exp_ok: 1'b0};
    vecs[5] = '{base: 4'd7,  len: 5'd31, first: 16'hDEAD, stp: 16'h0001, exp_ok: 1'b0};
    vecs[6] = '{base: 4'd15, len: 5'd1,  first: 16'h7777, stp: 16'h0000, exp_ok: 1'b1};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0;
    wr_valid = 1'b0; wr_data = '0; en = 1'b0; address = '0;
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(wr_ready), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_burst(vecs[i].base, vecs[i].len, vecs[i].first, vecs[i].stp, vecs[i].exp_ok, 0);
      if (vecs[i].exp_ok) readback(vecs[i].base, int'(vecs[i].len));
    end
    check("wrap_mem15", 32'(model[15]), 32'h7777);

    // stall mid-burst with an ignored start in WRITE
    do_burst(4'd2, 5'd5, 16'hD000, 16'h0001, 1'b1, 2);
    readback(4'd0, 16);

    // read-first collision at address 6, then en=0 holds
    held = model[6];
    start = 1'b1; base_addr = 4'd6; burst_len = 5'd1;
    @(negedge clk);
    start = 1'b0; wr_valid = 1'b1; wr_data = 16'hBEEF; en = 1'b1; address = 4'd6;
    @(negedge clk);
    model[6] = 16'hBEEF;
    wr_valid = 1'b0;
    check("collision_old_data", 32'(out), 32'(held));
    check("collision_done", 32'(done), 32'd1);
    @(negedge clk);
    check("collision_new_data", 32'(out), 32'h0000BEEF);
    en = 1'b0; address = 4'd3;
    @(negedge clk);
    @(negedge clk);
    check("en_low_holds", 32'(out), 32'h0000BEEF);

    // abort after 2 of 8 words
    start = 1'b1; base_addr = 4'd8; burst_len = 5'd8;
    @(negedge clk);
    start = 1'b0; wr_valid = 1'b1; wr_data = 16'hC001;
    @(negedge clk);
    wr_data = 16'hC002; en = 1'b1; address = 4'd8;
    @(negedge clk);
    wr_valid = 1'b0; en = 1'b0;
    model[8] = 16'hC001; model[9] = 16'hC002;
    check("abort_pre_out", 32'(out), 32'h0000C001);
    check("abort_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    readback(4'd8, 3);

    // start on the first edge after reset release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; base_addr = 4'd0; burst_len = 5'd1;
    @(negedge clk);
    start = 1'b0;
    check("start_after_reset", 32'(busy), 32'd1);
    wr_valid = 1'b1; wr_data = 16'h5A5A;
    @(negedge clk);
    model[0] = 16'h5A5A;
    wr_valid = 1'b0;
    check("post_reset_done", 32'(done), 32'd1);
    @(negedge clk);
    readback(4'd0, 1);

    // randomized bursts with interleaved reads
    for (int n = 0; n < 25; n++) begin
      rbase = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      if (r == 0) rlen = 5'd0;
      else if (r == 1) rlen = 5'($urandom_range(17, 31));
      else rlen = 5'($urandom_range(1, 16));
      do_burst(rbase, rlen, 16'($urandom), 16'($urandom), (rlen >= 5'd1 && rlen <= 5'd16), 1);
      if (rlen >= 5'd1 && rlen <= 5'd16) readback(rbase, int'(rlen));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_writer_16bit_4bit.md
RAM_BURST_WRITER_16BIT_4BIT -- requirements
Module: ram_burst_writer_16bit_4bit

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width in bits; depth is 2**ADDR_W = 16 words.
REQ-003 Port clk, input, 1, single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port start, input, 1, one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 Port base_addr, input, ADDR_W, first write address; sampled with start.
REQ-007 Port burst_len, input, ADDR_W+1, number of words in the burst, 1..16; sampled with start.
REQ-008 Port wr_valid, input, 1, producer has a word on wr_data.
REQ-009 Port wr_data, input, DATA_W, write data word.
REQ-010 Port wr_ready, output, 1, block accepts a word this cycle.
REQ-011 Port busy, output, 1, high in WRITE and DONE.
REQ-012 Port done, output, 1, one-cycle pulse when the burst completes.
REQ-013 Port en, input, 1, read enable.
REQ-014 Port address, input, ADDR_W, read address.
REQ-015 Port out, output, DATA_W, registered read data.

Function
REQ-016 FSM states: IDLE, WRITE, DONE.
REQ-017 Transition IDLE->WRITE on start=1 with burst_len in 1..16; latch wr_ptr=base_addr and remaining=burst_len.
REQ-018 In IDLE, start with burst_len=0 or >16 is ignored: the FSM stays in IDLE and done does not pulse.
REQ-019 wr_ready=1 only in WRITE; it is 0 in IDLE and DONE.
REQ-020 Handshake: a word is written when wr_valid & wr_ready at a clock edge; mem[wr_ptr] <= wr_data, wr_ptr increments, remaining decrements.
REQ-021 wr_valid=0 in WRITE stalls the burst with no write; the burst length has no timeout.
REQ-022 wr_ptr wraps modulo 16: 15 -> 0.
REQ-023 When the last word is accepted (remaining=1), the FSM goes WRITE->DONE; DONE->IDLE after exactly one cycle; done=1 only while in DONE.
REQ-024 start asserted during WRITE or DONE is ignored.
REQ-025 Read port: on a rising edge with en=1, out <= mem[address]; with en=0, out holds its value. Read latency is one cycle.
REQ-026 Read and write to the same address in the same cycle returns the old data (read-first); the new data is visible on the next enabled read.
REQ-027 The read port is independent of the FSM and operates in all states.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, out=0, wr_ready=0, busy=0, done=0, wr_ptr=0, remaining=0.
REQ-029 Memory contents are not reset; they are undefined until written.
REQ-030 rst_n asserted mid-burst aborts the burst; words already written stay in memory and no done pulse is produced.
REQ-031 After rst_n deasserts, the block accepts start on the first rising edge.

Structure
REQ-032 A shared package ram_pkg holds DATA_W, ADDR_W, DEPTH and the state enum {IDLE, WRITE, DONE}.
REQ-033 Storage is a sub-module memory_RAM_16bit_4bit with one synchronous write port and one registered read port (en/address/out); the FSM lives in the top module.

Verification
REQ-034 Reset: rst_n=0 mid-cycle -> out=0, busy=0, wr_ready=0 immediately, without waiting for a clock edge.
REQ-035 Burst: start, base_addr=3, burst_len=4, data 0xA001..0xA004 with continuous valid -> reads of addresses 3..6 return 0xA001..0xA004; done pulses exactly once, one cycle after the 4th accept.
REQ-036 Wrap: base_addr=14, burst_len=4, data 0x1111,0x2222,0x3333,0x4444 -> mem[14]=0x1111, mem[15]=0x2222, mem[0]=0x3333, mem[1]=0x4444.
REQ-037 Stall and ignore: wr_valid low for 3 cycles mid-burst -> no extra writes, the count is preserved; start pulsed during WRITE -> no effect; burst_len=0 -> stays IDLE.
REQ-038 Read behaviour: en=1, address=6 during the write of 0xBEEF to address 6 -> out shows the old value, the next read shows 0xBEEF; with en=0, out holds.
REQ-039 Abort: rst_n pulsed after 2 of 8 words -> state IDLE, no done pulse, the 2 written words are readable back.
